// File: rtl/bus_transfer_sequencer.sv
// Receiving-end bus sequencer: queues register-transfer commands, validates their codes,
// and replays them as registered one-hot driver/load strobe pairs on the datapath bus.
module bus_transfer_sequencer #(
   parameter int DEPTH = 4,
   parameter int NSRC  = 24,
   localparam int CW   = $clog2(DEPTH + 1)
) (
   input  logic            clock,
   input  logic            clear,
   input  logic            cmd_valid,
   output logic            cmd_ready,
   input  logic [4:0]      cmd_src,
   input  logic [4:0]      cmd_dst,
   input  logic            stall,
   output logic [NSRC-1:0] out_strobe,
   output logic [NSRC-1:0] in_strobe,
   output logic            xfer_done,
   output logic            cmd_error,
   output logic            busy,
   output logic [CW-1:0]   fifo_count
);

   localparam int              AW      = $clog2(DEPTH);
   localparam logic [5:0]      L_NSRC  = 6'(NSRC);
   localparam logic [NSRC-1:0] L_ONE   = NSRC'(1);
   localparam logic [CW-1:0]   L_DEPTH = CW'(DEPTH);

   typedef enum logic {IDLE, DRIVE} state_t;

   state_t          r_state;
   state_t          w_nextState;

   logic [9:0]      r_fifo [DEPTH];
   logic [AW-1:0]   r_wrPtr;
   logic [AW-1:0]   r_rdPtr;
   logic [CW-1:0]   r_count;

   logic [NSRC-1:0] r_outStrobe;
   logic [NSRC-1:0] r_inStrobe;
   logic            r_xferDone;
   logic            r_cmdError;

   logic            w_ready;
   logic            w_accept;
   logic            w_cmdBad;
   logic            w_push;
   logic            w_pop;
   logic            w_retire;
   logic            w_notEmpty;
   logic [4:0]      w_headSrc;
   logic [4:0]      w_headDst;

   // Full blocks acceptance on the current count only, even if a pop happens this edge.
   assign w_ready    = ~clear & (r_count < L_DEPTH);
   assign w_accept   = cmd_valid & w_ready;
   assign w_cmdBad   = ({1'b0, cmd_src} >= L_NSRC) | ({1'b0, cmd_dst} >= L_NSRC) |
                       (cmd_dst == 5'd22) | (cmd_dst == 5'd23) | (cmd_src == cmd_dst);
   assign w_push     = w_accept & ~w_cmdBad;
   assign w_notEmpty = (r_count != '0);
   assign w_headSrc  = r_fifo[r_rdPtr][9:5];
   assign w_headDst  = r_fifo[r_rdPtr][4:0];

   always_ff @(posedge clock) begin
      if (clear) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE: begin
            if (w_notEmpty) begin
               w_nextState = DRIVE;
            end
         end
         DRIVE: begin
            if (!stall && !w_notEmpty) begin
               w_nextState = IDLE;
            end
         end
         default: w_nextState = IDLE;
      endcase
   end

   always_comb begin
      w_pop    = 1'b0;
      w_retire = 1'b0;
      case (r_state)
         IDLE: begin
            w_pop = w_notEmpty;
         end
         DRIVE: begin
            w_retire = ~stall;
            w_pop    = ~stall & w_notEmpty;
         end
         default: begin
            w_pop    = 1'b0;
            w_retire = 1'b0;
         end
      endcase
   end

   // Storage needs no reset: entries are only read once the count says they were written.
   always_ff @(posedge clock) begin
      if (w_push) begin
         r_fifo[r_wrPtr] <= {cmd_src, cmd_dst};
      end
   end

   always_ff @(posedge clock) begin
      if (clear) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_wrPtr <= r_wrPtr + AW'(1);
         end
         if (w_pop) begin
            r_rdPtr <= r_rdPtr + AW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (clear) begin
         r_outStrobe <= '0;
         r_inStrobe  <= '0;
         r_xferDone  <= 1'b0;
         r_cmdError  <= 1'b0;
      end else begin
         if (w_pop) begin
            r_outStrobe <= L_ONE << w_headSrc;
            r_inStrobe  <= L_ONE << w_headDst;
         end else if (w_retire) begin
            r_outStrobe <= '0;
            r_inStrobe  <= '0;
         end
         r_xferDone <= w_retire;
         r_cmdError <= w_accept & w_cmdBad;
      end
   end

   assign cmd_ready  = w_ready;
   assign out_strobe = r_outStrobe;
   assign in_strobe  = r_inStrobe;
   assign xfer_done  = r_xferDone;
   assign cmd_error  = r_cmdError;
   assign busy       = (r_state == DRIVE) | w_notEmpty;
   assign fifo_count = r_count;

endmodule

// File: tb/tb_bus_transfer_sequencer.sv
// Self-checking bench for bus_transfer_sequencer: a queue-based transfer model predicts
// every output after each clock edge; scenario tasks add fixed expectations on top.
module tb_bus_transfer_sequencer;

   localparam int DEPTH = 4;
   localparam int NSRC  = 24;

   logic        clock = 1'b0;
   logic        clear;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [4:0]  cmd_src;
   logic [4:0]  cmd_dst;
   logic        stall;
   logic [23:0] out_strobe;
   logic [23:0] in_strobe;
   logic        xfer_done;
   logic        cmd_error;
   logic        busy;
   logic [2:0]  fifo_count;

   bus_transfer_sequencer #(.DEPTH(DEPTH), .NSRC(NSRC)) dut (
      .clock      (clock),
      .clear      (clear),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_src    (cmd_src),
      .cmd_dst    (cmd_dst),
      .stall      (stall),
      .out_strobe (out_strobe),
      .in_strobe  (in_strobe),
      .xfer_done  (xfer_done),
      .cmd_error  (cmd_error),
      .busy       (busy),
      .fifo_count (fifo_count)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   // Reference model: pending commands, the transfer on the bus, and last-cycle pulses.
   logic [9:0]  mQueue [$];
   logic        mOnBus = 1'b0;
   logic [4:0]  mSrc = '0;
   logic [4:0]  mDst = '0;
   logic        mDone = 1'b0;
   logic        mErr = 1'b0;
   logic        expReady;
   logic        obsReady;
   logic [54:0] expVec;
   logic [54:0] obsVec;

   function automatic logic [23:0] onehot(input logic [4:0] code);
      logic [23:0] one;
      one = 24'd1;
      return one << code;
   endfunction

   function automatic logic isBad(input logic [4:0] s, input logic [4:0] d);
      return (int'(s) >= NSRC) || (int'(d) >= NSRC) || (d == 5'd22) || (d == 5'd23) || (s == d);
   endfunction

   // Drives one cycle of inputs, advances the model, and captures observed/expected vectors.
   task automatic driveCycle(input logic v, input logic [4:0] s, input logic [4:0] d,
                             input logic st, input logic clr);
      logic        acc;
      logic [23:0] eo;
      logic [23:0] ei;
      cmd_valid = v;
      cmd_src   = s;
      cmd_dst   = d;
      stall     = st;
      clear     = clr;
      #1;
      obsReady = cmd_ready;
      if (clr) begin
         expReady = 1'b0;
         mQueue.delete();
         mOnBus = 1'b0;
         mDone  = 1'b0;
         mErr   = 1'b0;
      end else begin
         expReady = (mQueue.size() < DEPTH);
         acc      = v && expReady;
         mDone    = mOnBus && !st;
         mErr     = acc && isBad(s, d);
         if (!mOnBus || !st) begin
            if (mQueue.size() > 0) begin
               {mSrc, mDst} = mQueue.pop_front();
               mOnBus = 1'b1;
            end else begin
               mOnBus = 1'b0;
            end
         end
         if (acc && !isBad(s, d)) mQueue.push_back({s, d});
      end
      @(posedge clock);
      #1;
      eo = mOnBus ? onehot(mSrc) : 24'd0;
      ei = mOnBus ? onehot(mDst) : 24'd0;
      expVec = {expReady, eo, ei, mDone, mErr, (mOnBus || mQueue.size() != 0), 3'(mQueue.size())};
      obsVec = {obsReady, out_strobe, in_strobe, xfer_done, cmd_error, busy, fifo_count};
   endtask

   task automatic test_reset();
      for (int i = 0; i < 2; i++) begin
         driveCycle(1'b1, 5'(i + 1), 5'd0, 1'b0, 1'b1);
         checks++;
         if (obsVec !== expVec) begin
            errors++;
            $display("[TB] FAIL reset_hold cycle %0d: got %h expected %h", i, obsVec, expVec);
         end
      end
      checks++;
      if ({out_strobe, in_strobe, xfer_done, cmd_error, busy, fifo_count} !== 54'd0) begin
         errors++;
         $display("[TB] FAIL reset_outputs: got busy=%b count=%0d out=%h", busy, fifo_count, out_strobe);
      end
      driveCycle(1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
      checks++;
      if (cmd_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL reset_release_ready: got %b expected 1", cmd_ready);
      end
   endtask

   task automatic test_single_move();
      for (int i = 0; i < 4; i++) begin
         driveCycle(i == 0, 5'd21, 5'd3, 1'b0, 1'b0);
         checks++;
         if (obsVec !== expVec) begin
            errors++;
            $display("[TB] FAIL single_move cycle %0d: got %h expected %h", i, obsVec, expVec);
         end
         if (i == 1) begin
            checks++;
            if (out_strobe !== 24'h200000 || in_strobe !== 24'h000008) begin
               errors++;
               $display("[TB] FAIL single_move_strobes: got %h/%h expected 200000/000008", out_strobe, in_strobe);
            end
         end
         if (i == 2) begin
            checks++;
            if (xfer_done !== 1'b1 || busy !== 1'b0 || out_strobe !== 24'd0) begin
               errors++;
               $display("[TB] FAIL single_move_done: got done=%b busy=%b out=%h expected 1 0 0", xfer_done, busy, out_strobe);
            end
         end
      end
   endtask

   task automatic test_burst();
      int          sent = 0;
      int          doneCount = 0;
      logic [23:0] prevOut;
      logic [23:0] retired [$];
      for (int g = 0; g < 20 && sent < 5; g++) begin
         driveCycle(1'b1, 5'(sent), 5'(sent + 1), 1'b1, 1'b0);
         if (expReady) sent++;
         checks++;
         if (obsVec !== expVec) begin
            errors++;
            $display("[TB] FAIL burst_fill cycle %0d: got %h expected %h", g, obsVec, expVec);
         end
      end
      driveCycle(1'b1, 5'd5, 5'd6, 1'b1, 1'b0);
      checks++;
      if (obsReady !== 1'b0 || fifo_count !== 3'd4 || out_strobe !== onehot(5'd0)) begin
         errors++;
         $display("[TB] FAIL burst_full: got ready=%b count=%0d out=%h expected 0 4 000001", obsReady, fifo_count, out_strobe);
      end
      prevOut = out_strobe;
      for (int g = 0; g < 16; g++) begin
         driveCycle(sent < 6, 5'(sent), 5'(sent + 1), 1'b0, 1'b0);
         if (sent < 6 && expReady) sent++;
         checks++;
         if (obsVec !== expVec) begin
            errors++;
            $display("[TB] FAIL burst_drain cycle %0d: got %h expected %h", g, obsVec, expVec);
         end
         if (xfer_done === 1'b1) begin
            doneCount++;
            retired.push_back(prevOut);
         end
         prevOut = out_strobe;
      end
      checks++;
      if (doneCount != 6) begin
         errors++;
         $display("[TB] FAIL burst_done_count: got %0d expected 6", doneCount);
      end
      for (int i = 0; i < retired.size() && i < 6; i++) begin
         checks++;
         if (retired[i] !== onehot(5'(i))) begin
            errors++;
            $display("[TB] FAIL burst_order %0d: got %h expected %h", i, retired[i], onehot(5'(i)));
         end
      end
   endtask

   task automatic test_stall_hold();
      logic stallPat [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      int   held = 0;
      int   doneCount = 0;
      for (int i = 0; i < 8; i++) begin
         driveCycle(i == 0, 5'd20, 5'd19, stallPat[i], 1'b0);
         checks++;
         if (obsVec !== expVec) begin
            errors++;
            $display("[TB] FAIL stall_hold cycle %0d: got %h expected %h", i, obsVec, expVec);
         end
         if (out_strobe === 24'h100000 && in_strobe === 24'h080000) held++;
         if (xfer_done === 1'b1) doneCount++;
      end
      checks++;
      if (held != 4 || doneCount != 1) begin
         errors++;
         $display("[TB] FAIL stall_hold_counts: got held=%0d done=%0d expected 4 1", held, doneCount);
      end
   endtask

   task automatic test_rejects();
      logic [4:0] srcs [4] = '{5'd24, 5'd2, 5'd5, 5'd0};
      logic [4:0] dsts [4] = '{5'd1, 5'd22, 5'd5, 5'd23};
      int         errPulses = 0;
      logic       activity = 1'b0;
      for (int i = 0; i < 4; i++) begin
         for (int c = 0; c < 2; c++) begin
            driveCycle(c == 0, srcs[i], dsts[i], 1'b0, 1'b0);
            checks++;
            if (obsVec !== expVec) begin
               errors++;
               $display("[TB] FAIL reject %0d cycle %0d: got %h expected %h", i, c, obsVec, expVec);
            end
            if (cmd_error === 1'b1) errPulses++;
            if (out_strobe !== 24'd0 || in_strobe !== 24'd0 || fifo_count !== 3'd0) activity = 1'b1;
         end
      end
      checks++;
      if (errPulses != 4 || activity !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reject_summary: got pulses=%0d activity=%b expected 4 0", errPulses, activity);
      end
   endtask

   task automatic test_reset_mid();
      logic activity = 1'b0;
      for (int i = 0; i < 3; i++) begin
         driveCycle(1'b1, 5'(2 * i + 1), 5'(2 * i + 2), 1'b1, 1'b0);
         checks++;
         if (obsVec !== expVec) begin
            errors++;
            $display("[TB] FAIL reset_mid_queue cycle %0d: got %h expected %h", i, obsVec, expVec);
         end
      end
      driveCycle(1'b1, 5'd7, 5'd8, 1'b0, 1'b1);
      checks++;
      if ({out_strobe, in_strobe, xfer_done, cmd_error, busy, fifo_count} !== 54'd0) begin
         errors++;
         $display("[TB] FAIL reset_mid_zero: got out=%h in=%h done=%b busy=%b count=%0d", out_strobe, in_strobe, xfer_done, busy, fifo_count);
      end
      for (int i = 0; i < 5; i++) begin
         driveCycle(1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
         if (out_strobe !== 24'd0 || xfer_done !== 1'b0 || busy !== 1'b0) activity = 1'b1;
      end
      checks++;
      if (activity !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_mid_quiet: got activity=%b expected 0", activity);
      end
   endtask

   task automatic test_pointer_wrap();
      int          sent = 0;
      int          guard = 0;
      logic [23:0] prevOut;
      logic [23:0] retired [$];
      prevOut = out_strobe;
      while (guard < 200 && (sent < 10 || mOnBus || mQueue.size() != 0)) begin
         driveCycle(sent < 10, 5'(sent % 16), 5'd16, 1'($urandom_range(0, 1)), 1'b0);
         if (sent < 10 && expReady) sent++;
         checks++;
         if (obsVec !== expVec) begin
            errors++;
            $display("[TB] FAIL wrap cycle %0d: got %h expected %h", guard, obsVec, expVec);
         end
         if (xfer_done === 1'b1) retired.push_back(prevOut);
         prevOut = out_strobe;
         guard++;
      end
      checks++;
      if (retired.size() != 10) begin
         errors++;
         $display("[TB] FAIL wrap_done_count: got %0d expected 10 (cycles used %0d)", retired.size(), guard);
      end
      for (int i = 0; i < retired.size() && i < 10; i++) begin
         checks++;
         if (retired[i] !== onehot(5'(i % 16))) begin
            errors++;
            $display("[TB] FAIL wrap_order %0d: got %h expected %h", i, retired[i], onehot(5'(i % 16)));
         end
      end
   endtask

   task automatic test_random();
      logic [4:0] s;
      logic [4:0] d;
      for (int i = 0; i < 300; i++) begin
         s = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 23));
         d = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 21));
         driveCycle(1'($urandom_range(0, 1)), s, d, ($urandom_range(0, 2) == 0),
                    ($urandom_range(0, 63) == 0));
         checks++;
         if (obsVec !== expVec) begin
            errors++;
            $display("[TB] FAIL random cycle %0d: got %h expected %h", i, obsVec, expVec);
         end
         checks++;
         if ($countones(out_strobe) > 1 || $countones(in_strobe) > 1) begin
            errors++;
            $display("[TB] FAIL random_onehot cycle %0d: got %h/%h expected at most one bit", i, out_strobe, in_strobe);
         end
      end
   endtask

   initial begin
      clear     = 1'b1;
      cmd_valid = 1'b0;
      cmd_src   = '0;
      cmd_dst   = '0;
      stall     = 1'b0;
      test_reset();
      test_single_move();
      test_burst();
      test_stall_hold();
      test_rejects();
      test_reset_mid();
      test_pointer_wrap();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
